// File: rtl/muldiv_if.sv
// muldiv_if: request and response channels of the muldiv_seq multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] d;
  logic            out_err;
  modport master (output in_valid, op, a, b, kill, out_ready, input in_ready, out_valid, d, out_err);
  modport slave (input in_valid, op, a, b, kill, out_ready, output in_ready, out_valid, d, out_err);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: radix-2 sequential RV32M multiply/divide sharing one shift datapath.
// The divide/remainder path is built only with MULDIV_DIV_EN; otherwise ops 4-7 report out_err.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave io
);
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  state_t            st_q, st_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, d_q, d_d;
  logic [2*XLEN-1:0] p_q, p_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sa_q, sa_d, sb_q, sb_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic              is_div, sa, sb;
  logic [XLEN-1:0]   abs_a, abs_b, q_fix, r_fix;
  logic [XLEN:0]     sum, rsh, diff;
  logic [2*XLEN-1:0] mul_nx, div_nx, p_fix;
  assign is_div = op_q[2];
  assign sa     = a_q[XLEN-1] & (op_q == 3'd1 | op_q == 3'd2 | (is_div & ~op_q[0]));
  assign sb     = b_q[XLEN-1] & (op_q == 3'd1 | (is_div & ~op_q[0]));
  assign abs_a  = sa ? -a_q : a_q;
  assign abs_b  = sb ? -b_q : b_q;
  // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign sum    = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, (p_q[0] ? a_q : {XLEN{1'b0}})};
  assign mul_nx = {sum, p_q[XLEN-1:1]};
  assign rsh    = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
  assign diff   = rsh - {1'b0, b_q};
  assign div_nx = diff[XLEN] ? {rsh[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                             : {diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
  assign p_fix  = (sa_q ^ sb_q) ? -p_q : p_q;
  assign q_fix  = (sa_q ^ sb_q) ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
  assign r_fix  = sa_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
  always_comb begin
    st_d        = st_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    case (st_q)
      IDLE: begin
        if (io.in_valid) begin
          op_d = io.op;
          a_d  = io.a;
          b_d  = io.b;
          st_d = PREP;
        end
      end
      PREP: begin
        st_d        = DONE;
        out_valid_d = 1'b1;
        out_err_d   = is_div & ~DIV_EN;
        if (is_div && !DIV_EN) begin
          d_d = '0;
        end else if (is_div && b_q == '0) begin
          d_d = op_q[1] ? a_q : '1;
        end else if (is_div && !op_q[0] && a_q == MIN_NEG && b_q == '1) begin
          d_d = op_q[1] ? '0 : a_q;
        end else begin
          st_d        = CALC;
          out_valid_d = 1'b0;
          sa_d        = sa;
          sb_d        = sb;
          a_d         = abs_a;
          b_d         = abs_b;
          p_d         = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
          cnt_d       = CW'(XLEN);
        end
      end
      CALC: begin
        p_d   = (is_div && DIV_EN) ? div_nx : mul_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) st_d = FIX;
      end
      FIX: begin
        d_d         = is_div ? (op_q[1] ? r_fix : q_fix)
                             : (op_q[1:0] == 2'd0 ? p_fix[XLEN-1:0] : p_fix[2*XLEN-1:XLEN]);
        out_err_d   = 1'b0;
        out_valid_d = 1'b1;
        st_d        = DONE;
      end
      DONE: begin
        if (io.out_ready) begin
          st_d        = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: st_d = IDLE;
    endcase
    // kill overrides everything, including acceptance in IDLE and delivery in DONE
    if (io.kill) begin
      st_d        = IDLE;
      out_valid_d = 1'b0;
    end
    in_ready_d = st_d == IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      d_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      d_q         <= d_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end
  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.d         = d_q;
  assign io.out_err   = out_err_q;
endmodule
